// File: rtl/raycast_frame_scheduler_if.sv
// Ray request/response handshake between the frame scheduler and the column
// raycast engine.
//   ray_start  : one-cycle request, scheduler -> engine
//   ray_col    : column of the current request, held from ray_start until ray_done
//   ray_done   : one-cycle completion, engine -> scheduler
//   ray_height : wall height for ray_col, valid with ray_done
// modport master is the scheduler side, modport slave is the engine side.
interface raycast_frame_scheduler_if #(
  parameter int COL_W    = 10,
  parameter int HEIGHT_W = 9
);
  logic                ray_start;
  logic [COL_W-1:0]    ray_col;
  logic                ray_done;
  logic [HEIGHT_W-1:0] ray_height;

  modport master (
    output ray_start,
    output ray_col,
    input  ray_done,
    input  ray_height
  );

  modport slave (
    input  ray_start,
    input  ray_col,
    output ray_done,
    output ray_height
  );
endinterface

// File: rtl/raycast_frame_scheduler.sv
// Per-frame column raycast scheduler with double-buffered wall heights.
// Issues one ray per visible column into the back buffer, swaps buffers at the
// start of vertical blanking, and serves the front buffer to the pixel pipeline.
//
// Ports (all in the pixel_clk domain, synchronous active-high reset):
//   pixel_clk, reset       : clock and reset
//   data_initialised       : map/player data valid; scheduler idles while low
//   h_pos, v_pos           : beam position from the sync generator
//   ray_if (master)        : ray_start/ray_col out, ray_done/ray_height in
//   disp_height            : registered front-buffer height for h_pos
//   frame_swap             : one-cycle pulse in the cycle the buffers swap
//   overrun                : sticky, a swap boundary hit an unfinished frame
//   ray_timeout            : sticky, the watchdog abandoned a ray
//
// Build option RAY_WATCHDOG_EN: adds a per-ray watchdog (RAY_TIMEOUT cycles in
// WAIT_DONE) that writes height 0 and moves on. Without it WAIT_DONE waits
// indefinitely and ray_timeout is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | data not initialised, nothing issued
// WAIT_VB   | armed, waiting for first boundary to start a frame (no swap)
// ISSUE     | ray_start pulse for col
// WAIT_DONE | waiting for the engine to return col's height
// DONE      | back buffer complete, waiting for boundary to swap
module raycast_frame_scheduler #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int COL_W     = 10,
  parameter int HEIGHT_W  = 9
`ifdef RAY_WATCHDOG_EN
  ,
  parameter int RAY_TIMEOUT = 1023
`endif
) (
  input  logic                      pixel_clk,
  input  logic                      reset,
  input  logic                      data_initialised,
  input  logic [COL_W-1:0]          h_pos,
  input  logic [9:0]                v_pos,
  raycast_frame_scheduler_if.master ray_if,
  output logic [HEIGHT_W-1:0]       disp_height,
  output logic                      frame_swap,
  output logic                      overrun,
  output logic                      ray_timeout
);

  typedef enum logic [2:0] {IDLE, WAIT_VB, ISSUE, WAIT_DONE, DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_DISPLAY - 1);
  localparam logic [COL_W:0]   H_LIMIT  = (COL_W + 1)'(H_DISPLAY);
  localparam logic [9:0]       V_SWAP   = 10'(V_DISPLAY);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                front_sel_q, front_sel_d;
  logic                front_valid_q, front_valid_d;
  logic                overrun_q, overrun_d;
  logic [HEIGHT_W-1:0] disp_height_q, disp_height_d;

  logic [HEIGHT_W-1:0] line_buf [2][H_DISPLAY];

  logic                boundary, last_col, col_done, timed_out, do_swap, wr_en;
  logic [HEIGHT_W-1:0] wr_data;

  assign boundary = (h_pos == '0) && (v_pos == V_SWAP);
  assign last_col = (col_q == LAST_COL);
  assign col_done = ray_if.ray_done | timed_out;
  // A real completion always wins over an expiring watchdog.
  assign wr_data  = ray_if.ray_done ? ray_if.ray_height : '0;

`ifdef RAY_WATCHDOG_EN
  localparam int WDOG_W = (RAY_TIMEOUT > 1) ? $clog2(RAY_TIMEOUT + 1) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              ray_timeout_q, ray_timeout_d;

  // Loaded during ISSUE so terminal count lands on the RAY_TIMEOUT-th WAIT_DONE cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ISSUE) begin
      wdog_d = WDOG_W'(RAY_TIMEOUT - 1);
    end else if ((state_q == WAIT_DONE) && (wdog_q != '0)) begin
      wdog_d = wdog_q - 1'b1;
    end
  end

  assign timed_out     = (state_q == WAIT_DONE) && (wdog_q == '0) && !ray_if.ray_done;
  assign ray_timeout_d = ray_timeout_q | (timed_out & data_initialised);
  assign ray_timeout   = ray_timeout_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      wdog_q        <= '0;
      ray_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      ray_timeout_q <= ray_timeout_d;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign ray_timeout = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    col_d            = col_q;
    front_sel_d      = front_sel_q;
    front_valid_d    = front_valid_q;
    overrun_d        = overrun_q;
    wr_en            = 1'b0;
    do_swap          = 1'b0;
    frame_swap       = 1'b0;
    ray_if.ray_start = 1'b0;

    if (!data_initialised) begin
      // Front buffer is left alone so the display keeps the last frame.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_VB;
        WAIT_VB: begin
          if (boundary) begin
            col_d   = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          ray_if.ray_start = 1'b1;
          state_d          = WAIT_DONE;
          if (boundary) overrun_d = 1'b1;
        end
        WAIT_DONE: begin
          if (col_done) begin
            wr_en = 1'b1;
            if (!last_col) begin
              col_d   = col_q + 1'b1;
              state_d = ISSUE;
            end else if (boundary) begin
              // Last height lands in the same cycle as the boundary: frame counts as complete.
              do_swap = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
          if (boundary && !(col_done && last_col)) overrun_d = 1'b1;
        end
        DONE: begin
          if (boundary) do_swap = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (do_swap) begin
        front_sel_d   = ~front_sel_q;
        front_valid_d = 1'b1;
        frame_swap    = 1'b1;
        col_d         = '0;
        state_d       = ISSUE;
      end
    end
  end

  always_comb begin
    disp_height_d = '0;
    if (front_valid_q && ({1'b0, h_pos} < H_LIMIT)) begin
      disp_height_d = line_buf[front_sel_q][h_pos];
    end
  end

  // Write uses the pre-swap selector, so a same-cycle swap still writes the old back.
  always_ff @(posedge pixel_clk) begin
    if (wr_en) line_buf[~front_sel_q][col_q] <= wr_data;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      disp_height_q <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      overrun_q     <= overrun_d;
      disp_height_q <= disp_height_d;
    end
  end

  assign ray_if.ray_col = col_q;
  assign disp_height    = disp_height_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_raycast_frame_scheduler.sv
`timescale 1ns/1ps
module tb_raycast_frame_scheduler;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int COL_W     = 10;
  localparam int HEIGHT_W  = 9;

  logic                pixel_clk = 1'b0;
  logic                reset;
  logic                data_initialised;
  logic [COL_W-1:0]    h_pos;
  logic [9:0]          v_pos;
  logic [HEIGHT_W-1:0] disp_height;
  logic                frame_swap, overrun, ray_timeout;

  raycast_frame_scheduler_if #(.COL_W(COL_W), .HEIGHT_W(HEIGHT_W)) ray_if ();

  raycast_frame_scheduler #(
    .H_DISPLAY(H_DISPLAY), .V_DISPLAY(V_DISPLAY), .COL_W(COL_W), .HEIGHT_W(HEIGHT_W)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .data_initialised(data_initialised),
    .h_pos(h_pos), .v_pos(v_pos), .ray_if(ray_if), .disp_height(disp_height),
    .frame_swap(frame_swap), .overrun(overrun), .ray_timeout(ray_timeout)
  );

  always #20 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // engine model and scoreboard state
  int cyc = 0;
  int delay = 3;
  int salt = 0;
  int ignore_col = -1;
  bit stray_req = 0;
  bit pend = 0;
  int pend_due = 0;
  logic [8:0] pend_h;
  bit outstanding = 0;
  int out_col = 0;
  int n_starts = 0;
  int swap_cnt = 0;
  int swap_cyc = -1;
  int frame_target = 0;
  int last_start_col = -1;
  int start_cyc [H_DISPLAY];
  logic [8:0] model_buf [2][H_DISPLAY];
  bit model_sel = 0;
  bit model_valid = 0;
  int exp_col_q [$];
  logic [8:0] disp_q [$];
  bit disp_stage_v = 0;
  logic [8:0] disp_stage;

  // engine: answers each request 'delay' cycles after its ray_start
  initial begin
    ray_if.ray_done   = 1'b0;
    ray_if.ray_height = '0;
    forever begin
      @(posedge pixel_clk);
      cyc++;
      #1;
      if (stray_req) begin
        ray_if.ray_done   = 1'b1;
        ray_if.ray_height = 9'h1FF;
        stray_req         = 0;
      end else if (pend && cyc == pend_due) begin
        ray_if.ray_done   = 1'b1;
        ray_if.ray_height = pend_h;
        pend              = 0;
      end else begin
        ray_if.ray_done = 1'b0;
      end
    end
  end

  // monitor: sampled mid-cycle
  initial begin
    forever begin
      @(negedge pixel_clk);
      if (reset) continue;
      if (!data_initialised) outstanding = 0;
      if (ray_if.ray_done && outstanding) begin
        model_buf[!model_sel][out_col] = ray_if.ray_height;
        outstanding = 0;
      end
      if (ray_if.ray_start) begin
        int c;
        c = int'(ray_if.ray_col);
        if (exp_col_q.size() == 0) chk("start_unexp", ray_if.ray_start, 0);
        else chk("ray_col", ray_if.ray_col, exp_col_q.pop_front());
        if (outstanding) begin
`ifdef RAY_WATCHDOG_EN
          model_buf[!model_sel][out_col] = 9'd0;
`else
          chk("start_busy", ray_if.ray_start, 0);
`endif
        end
        n_starts++;
        last_start_col = c;
        if (c < H_DISPLAY) start_cyc[c] = cyc;
        outstanding = 1;
        out_col = c;
        if (c != ignore_col) begin
          pend     = 1;
          pend_due = cyc + delay;
          pend_h   = 9'(c + salt);
        end
      end
      if (frame_swap) begin
        swap_cnt++;
        swap_cyc    = cyc;
        model_sel   = !model_sel;
        model_valid = 1;
      end
      if (disp_stage_v) chk("disp", disp_height, disp_stage);
      disp_stage_v = 0;
      if (disp_q.size() > 0) begin
        disp_stage   = disp_q.pop_front();
        disp_stage_v = 1;
      end
    end
  end

  task automatic step();
    @(posedge pixel_clk);
    #2;
  endtask

  task automatic drive_h(input int h);
    logic [8:0] e;
    e = 9'd0;
    if (h < H_DISPLAY && model_valid) e = model_buf[model_sel][h];
    h_pos = 10'(h);
    v_pos = 10'd0;
    disp_q.push_back(e);
    step();
  endtask

  task automatic sweep();
    for (int h = 0; h < 800; h++) drive_h(h);
    h_pos = 10'd1;
    step();
    step();
  endtask

  task automatic boundary();
    h_pos = 10'd0;
    v_pos = 10'(V_DISPLAY);
    step();
    v_pos = 10'd0;
    h_pos = 10'd1;
  endtask

  task automatic push_frame();
    for (int c = 0; c < H_DISPLAY; c++) exp_col_q.push_back(c);
    frame_target = n_starts + H_DISPLAY;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int i;
    i = 0;
    while ((n_starts < frame_target || outstanding) && i < budget) begin
      step();
      i++;
    end
    chk(tag, (n_starts == frame_target) && !outstanding, 1);
  endtask

  initial begin
    int sc, bcyc, due, base, i, s0;
    reset = 1'b1;
    data_initialised = 1'b0;
    h_pos = '0;
    v_pos = '0;
    repeat (3) step();
    @(negedge pixel_clk);
    chk("rst_start", ray_if.ray_start, 0);
    chk("rst_col", ray_if.ray_col, 0);
    chk("rst_swap", frame_swap, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", ray_timeout, 0);
    chk("rst_disp", disp_height, 0);
    step();
    reset = 1'b0;

    // first frame: nothing shown before the first swap
    data_initialised = 1'b1;
    sweep();
    chk("pre_starts", n_starts, 0);
    push_frame();
    sc = swap_cnt;
    boundary();
    chk("first_vb_swap", swap_cnt, sc);
    wait_frame("frame1", 4000);
    stray_req = 1;
    repeat (4) step();
    salt = 7;
    push_frame();
    sc = swap_cnt;
    boundary();
    chk("swap1", swap_cnt, sc + 1);
    h_pos = 10'd100;
    disp_q.push_back(9'd100);
    step();
    sweep();

    // last ray_done coincides with the boundary
    i = 0;
    while (n_starts < frame_target && i < 4000) begin step(); i++; end
    chk("frame2_starts", n_starts, frame_target);
    due = start_cyc[H_DISPLAY-1] + delay;
    while (cyc < due) step();
    salt = 21;
    push_frame();
    sc = swap_cnt;
    bcyc = cyc;
    boundary();
    chk("sim_swap_cnt", swap_cnt, sc + 1);
    chk("sim_swap_cyc", swap_cyc, bcyc);
    step();
    chk("sim_next_start", start_cyc[0], bcyc + 1);
    chk("sim_overrun", overrun, 0);
    sweep();

    // drop data_initialised mid-frame
    i = 0;
    while (last_start_col != 300 && i < 3000) begin step(); i++; end
    chk("drop_at", last_start_col, 300);
    data_initialised = 1'b0;
    exp_col_q.delete();
    s0 = n_starts;
    sweep();
    chk("drop_no_start", n_starts, s0);
    data_initialised = 1'b1;
    repeat (50) step();
    chk("reraise_no_start", n_starts, s0);

    // slow engine: boundary hits an unfinished frame
    chk("overrun_clear", overrun, 0);
    delay = 600;
    salt = 33;
    push_frame();
    sc = swap_cnt;
    boundary();
    chk("rearm_no_swap", swap_cnt, sc);
    repeat (300) step();
    boundary();
    @(negedge pixel_clk);
    chk("overrun_set", overrun, 1);
    chk("overrun_no_swap", swap_cnt, sc);
    delay = 3;
    wait_frame("frame_ovr", 4000);
    chk("ovr_no_early_swap", swap_cnt, sc);
`ifdef RAY_WATCHDOG_EN
    ignore_col = 5;
`endif
    salt = 50;
    push_frame();
    base = n_starts;
    boundary();
    chk("ovr_swap", swap_cnt, sc + 1);
    chk("overrun_sticky", overrun, 1);
    sweep();

`ifdef RAY_WATCHDOG_EN
    i = 0;
    while (n_starts < base + 7 && i < 3000) begin step(); i++; end
    chk("wd_started6", n_starts >= base + 7, 1);
    chk("wd_gap", start_cyc[6] - start_cyc[5], 1024);
    chk("wd_flag", ray_timeout, 1);
    wait_frame("frame_wd", 4000);
    ignore_col = -1;
    push_frame();
    boundary();
    h_pos = 10'd5;
    disp_q.push_back(9'd0);
    step();
    drive_h(6);
    step();
    step();
`else
    chk("no_wd_flag", ray_timeout, 0);
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/raycast_frame_scheduler.md
Name: raycast_frame_scheduler

Overview:
- Sequences the column raycasting engine once per frame: issues one ray request per screen column, 0..H_DISPLAY-1, and stores each returned wall height in a back buffer.
- Swaps back and front buffers at the start of vertical blanking.
- Serves the front buffer to the pixel pipeline, indexed by the h_pos/v_pos stream from the VGA sync generator.
- Sits between the sync generator, the raycast engine and the pixel colouring logic, all in the pixel_clk domain.

Parameters:
- H_DISPLAY, 640, visible columns / rays per frame
- V_DISPLAY, 480, first blanking line (swap boundary)
- COL_W, 10, column index width
- HEIGHT_W, 9, wall height width
- RAY_TIMEOUT, 1023, max cycles waiting for ray_done (optional feature)

Ports:
- pixel_clk  in  1  25 MHz pixel clock
- reset  in  1  synchronous, active-high
- data_initialised  in  1  map/player data valid; scheduler idles while low
- h_pos  in  COL_W  current pixel column from sync generator
- v_pos  in  10  current line from sync generator
- ray_start  out  1  one-cycle request to raycast engine
- ray_col  out  COL_W  column for current request; stable from ray_start until ray_done
- ray_done  in  1  one-cycle completion from engine
- ray_height  in  HEIGHT_W  wall height, valid with ray_done
- disp_height  out  HEIGHT_W  front-buffer height for column h_pos
- frame_swap  out  1  one-cycle pulse on buffer swap
- overrun  out  1  sticky: a swap boundary arrived before the frame completed
- ray_timeout  out  1  sticky: a ray was abandoned by the watchdog

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE, col counter 0, front_sel 0, front_valid 0
  - buffer contents not reset
- Storage: two arrays of H_DISPLAY x HEIGHT_W, back = !front_sel.
- Boundary event: asserted in any cycle where h_pos==0 and v_pos==V_DISPLAY.
- States:
  - IDLE: wait for data_initialised=1, then go to WAIT_VB.
  - WAIT_VB: wait for the boundary event, then set col=0 and go to ISSUE. No swap on this first boundary.
  - ISSUE: drive ray_start=1 for exactly one cycle with ray_col=col, then go to WAIT_DONE.
  - WAIT_DONE: on ray_done, write back[col]=ray_height.
    - If col==H_DISPLAY-1, go to DONE.
    - Otherwise col+1 and go to ISSUE.
    - Minimum 2 cycles per column.
  - DONE: on the boundary event, toggle front_sel, set front_valid=1, pulse frame_swap, set col=0 and go to ISSUE.
- Boundary event while in ISSUE or WAIT_DONE (frame incomplete):
  - set overrun=1
  - no swap
  - continue the current frame; the swap waits for the next boundary after DONE
- Simultaneous events: ray_done for column H_DISPLAY-1 in the same cycle as the boundary event counts as complete.
  - The write lands in back, the swap happens that cycle and frame_swap pulses.
  - The next cycle is ISSUE with col=0.
  - overrun is not set.
- Stray inputs: ray_done outside WAIT_DONE is ignored and no write occurs.
- data_initialised falling in any state: go to IDLE next cycle.
  - ray_start is forced to 0.
  - Any pending ray_done is ignored.
  - front_sel and front_valid are unchanged, so the display keeps showing the last frame.
- Display read:
  - disp_height is registered: front[h_pos] when h_pos<H_DISPLAY and front_valid=1, else 0.
  - Latency is 1 cycle from h_pos.
- Sticky flags overrun and ray_timeout clear only on reset.
- col is COL_W bits and never exceeds H_DISPLAY-1.

Optional Feature:
- Macro RAY_WATCHDOG_EN.
- Defined:
  - WAIT_DONE counts cycles. When the count reaches RAY_TIMEOUT with no ray_done, write back[col]=0 and set ray_timeout=1.
  - Then advance exactly as if ray_done had arrived.
  - ray_done arriving in the same cycle as expiry takes priority: ray_height is written and no timeout is flagged.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - ray_timeout is tied to 0.

Test Plan:
- Reset, data_initialised=1, engine answers 3 cycles after each ray_start with ray_height=col[8:0], first boundary at (0,480):
  - 640 ray_start pulses, col 0..639
  - frame_swap pulses at the next (0,480)
  - then disp_height at h_pos=100 is 100 one cycle later
- Before the first swap, sweep h_pos 0..799 → disp_height stays 0.
- With front_valid=1, h_pos 640..799 → disp_height=0.
- Engine delays 600 cycles per ray:
  - the boundary arrives at column 0..1 → overrun=1, no frame_swap
  - the swap occurs at the first boundary after column 639 completes
- ray_done for col 639 in the same cycle as the boundary at (0,480) → frame_swap=1 that cycle, overrun stays 0, ray_start with col 0 on the next cycle.
- Drop data_initialised mid-frame at col 300 → ray_start stays 0 and disp_height keeps the old front contents. Re-raise → no ray_start until the next (0,480).
- RAY_WATCHDOG_EN defined, engine ignores col 5 → after 1023 cycles, ray_timeout=1, back[5]=0, ray_start issued for col 6.
